// File: rtl/prog_sequencer.sv
// Instruction sequencer for the 9-bit procc: fetches from a synchronous ROM, issues
// Run/DIN (plus MVI immediate), waits for Done, with start/halt/step and a Done watchdog.
module prog_sequencer #(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              halt_req,
  input  logic              step_mode,
  input  logic              step,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [8:0]        mem_rdata,
  output logic [8:0]        DIN,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [CNT_W-1:0]  instr_cnt
);

  localparam int unsigned TIMER_W = 8;
  localparam logic [2:0]  OP_MVI  = 3'b001;
  localparam logic [2:0]  OP_HALT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LATCH, S_IMMF, S_IMML, S_ISSUE,
    S_IMMDRV, S_WAITD, S_RETIRE, S_PAUSE, S_HALTED, S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [8:0]          ir_q, ir_d;
  logic [8:0]          imm_q, imm_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [8:0]          din_q, din_d;
  logic                run_q, run_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                error_q, error_d;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = start_addr;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        ir_d = mem_rdata;
        pc_d = pc_q + ADDR_W'(1);
        if (mem_rdata[8:6] == OP_HALT)     state_d = S_HALTED;
        else if (mem_rdata[8:6] == OP_MVI) state_d = S_IMMF;
        else                               state_d = S_ISSUE;
      end
      S_IMMF: state_d = S_IMML;
      S_IMML: begin
        imm_d   = mem_rdata;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = (ir_q[8:6] == OP_MVI) ? S_IMMDRV : S_WAITD;
      end
      // procc completes MVI while the immediate is on DIN
      S_IMMDRV: state_d = S_RETIRE;
      S_WAITD: begin
        if (Done) begin
          state_d = S_RETIRE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
          if (timer_d == TIMER_W'(TIMEOUT)) state_d = S_ERROR;
        end
      end
      S_RETIRE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (halt_req)       state_d = S_HALTED;
        else if (step_mode) state_d = S_PAUSE;
        else                state_d = S_FETCH;
      end
      S_PAUSE: begin
        if (halt_req)  state_d = S_HALTED;
        else if (step) state_d = S_FETCH;
      end
      S_HALTED: begin
        if (start) begin
          pc_d    = start_addr;
          state_d = S_FETCH;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    din_d    = (state_d == S_ISSUE)  ? ir_d :
               (state_d == S_IMMDRV) ? imm_d : 9'd0;
    run_d    = (state_d == S_ISSUE);
    busy_d   = !(state_d inside {S_IDLE, S_HALTED, S_ERROR, S_PAUSE});
    halted_d = (state_d == S_HALTED);
    error_d  = (state_d == S_ERROR);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      imm_q    <= '0;
      timer_q  <= '0;
      cnt_q    <= '0;
      din_q    <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      imm_q    <= imm_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      din_q    <= din_d;
      run_q    <= run_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      error_q  <= error_d;
    end
  end

  assign mem_addr  = pc_q;
  assign pc        = pc_q;
  assign DIN       = din_q;
  assign Run       = run_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign error     = error_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: sync ROM plus a small procc behavioural model.
module tb_prog_sequencer;

  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned CNT_W   = 16;

  logic              Clock = 1'b0;
  logic              Resetn = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              halt_req = 1'b0;
  logic              step_mode = 1'b0;
  logic              step = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [8:0]        mem_rdata = '0;
  logic [8:0]        DIN;
  logic              Run;
  logic              Done;
  logic [ADDR_W-1:0] pc;
  logic              busy, halted, error;
  logic [CNT_W-1:0]  instr_cnt;

  int errors = 0;
  int checks = 0;

  prog_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .start_addr(start_addr),
    .halt_req(halt_req), .step_mode(step_mode), .step(step),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .DIN(DIN), .Run(Run), .Done(Done),
    .pc(pc), .busy(busy), .halted(halted), .error(error), .instr_cnt(instr_cnt)
  );

  always #5 Clock = ~Clock;

  // Synchronous program ROM
  logic [8:0] rom [128];
  always @(posedge Clock) mem_rdata <= rom[mem_addr];

  // procc model: MV/MVI Done in T1, ADD/SUB Done in T3
  logic [8:0] r [8];
  logic [8:0] pir;
  logic [1:0] tstep;
  logic       done_en = 1'b1;
  assign Done = done_en &&
                ((tstep == 2'd1 && (pir[8:6] == 3'd0 || pir[8:6] == 3'd1)) ||
                 (tstep == 2'd3 && (pir[8:6] == 3'd2 || pir[8:6] == 3'd3)));

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tstep <= 2'd0;
      pir   <= 9'd0;
      for (int i = 0; i < 8; i++) r[i] <= 9'd0;
    end else if (Run) begin
      pir   <= DIN;
      tstep <= 2'd1;
    end else begin
      case (tstep)
        2'd1: begin
          if (pir[8:6] == 3'd1) begin
            r[pir[5:3]] <= DIN;
            tstep <= 2'd0;
          end else if (pir[8:6] == 3'd0) begin
            r[pir[5:3]] <= r[pir[2:0]];
            tstep <= 2'd0;
          end else begin
            tstep <= 2'd2;
          end
        end
        2'd2: tstep <= 2'd3;
        2'd3: begin
          if (done_en) begin
            if (pir[8:6] == 3'd2) r[pir[5:3]] <= r[pir[5:3]] + r[pir[2:0]];
            else                  r[pir[5:3]] <= r[pir[5:3]] - r[pir[2:0]];
            tstep <= 2'd0;
          end
        end
        default: tstep <= 2'd0;
      endcase
    end
  end

  // Run pulse bookkeeping
  int              run_total = 0;
  int              run_double = 0;
  logic            run_prev = 1'b0;
  logic [ADDR_W-1:0] run_pc = '0;
  always @(posedge Clock) begin
    if (Run) run_total <= run_total + 1;
    if (Run && run_prev) run_double <= run_double + 1;
    if (Run) run_pc <= pc;
    run_prev <= Run;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Resetn = 1'b0; start = 1'b0; halt_req = 1'b0; step = 1'b0; step_mode = 1'b0;
    done_en = 1'b1;
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 9'd0;
  endtask

  task automatic load_prog1();
    clear_rom();
    rom[0] = 9'h040; rom[1] = 9'h005; rom[2] = 9'h008; rom[3] = 9'h081; rom[4] = 9'h1C0;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] a);
    @(negedge Clock);
    start = 1'b1; start_addr = a;
    @(negedge Clock);
    start = 1'b0;
  endtask

  task automatic wait_halted(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (halted) break;
      @(negedge Clock);
    end
    check_eq(tag, 32'(halted), 32'd1);
  endtask

  task automatic wait_pause(input string tag, input int n);
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (!busy && !halted && !error && int'(instr_cnt) == n) break;
    end
    check_eq(tag, 32'(instr_cnt), 32'(n));
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_issue(input string tag, input logic [8:0] ins);
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (Run && DIN == ins) break;
    end
    check_eq(tag, 32'(DIN), 32'(ins));
  endtask

  int base;
  int n;

  initial begin
    clear_rom();
    // Reset values
    #12;
    check_eq("rst_pc", 32'(pc), 32'd0);
    check_eq("rst_cnt", 32'(instr_cnt), 32'd0);
    check_eq("rst_din_run", {22'd0, DIN, Run}, 32'd0);
    check_eq("rst_flags", {29'd0, busy, halted, error}, 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;

    // 1: basic program
    load_prog1();
    base = run_total;
    pulse_start(7'd0);
    wait_halted("t1_halt");
    check_eq("t1_r0", 32'(r[0]), 32'd10);
    check_eq("t1_r1", 32'(r[1]), 32'd5);
    check_eq("t1_pc", 32'(pc), 32'd5);
    check_eq("t1_cnt", 32'(instr_cnt), 32'd3);
    check_eq("t1_runs", 32'(run_total - base), 32'd3);

    // 2: MVI straddling address wrap
    do_reset();
    clear_rom();
    rom[127] = 9'h040; rom[0] = 9'h007; rom[1] = 9'h1C0;
    pulse_start(7'd127);
    wait_halted("t2_halt");
    check_eq("t2_r0", 32'(r[0]), 32'd7);
    check_eq("t2_issue_pc", 32'(run_pc), 32'd1);
    check_eq("t2_pc", 32'(pc), 32'd2);
    check_eq("t2_cnt", 32'(instr_cnt), 32'd1);

    // 3: single-step
    do_reset();
    load_prog1();
    step_mode = 1'b1;
    pulse_start(7'd0);
    wait_pause("t3_p1", 1);
    repeat (5) @(negedge Clock);
    check_eq("t3_hold", 32'(instr_cnt), 32'd1);
    step = 1'b1; @(negedge Clock); step = 1'b0;
    wait_pause("t3_p2", 2);
    check_eq("t3_r1", 32'(r[1]), 32'd5);
    step = 1'b1; @(negedge Clock); step = 1'b0;
    wait_pause("t3_p3", 3);
    check_eq("t3_r0", 32'(r[0]), 32'd10);
    step = 1'b1; halt_req = 1'b1;
    @(negedge Clock);
    step = 1'b0; halt_req = 1'b0;
    check_eq("t3_halted", 32'(halted), 32'd1);
    check_eq("t3_pc", 32'(pc), 32'd4);
    check_eq("t3_cnt", 32'(instr_cnt), 32'd3);
    step_mode = 1'b0;

    // 4: Done watchdog
    do_reset();
    clear_rom();
    rom[0] = 9'h081;
    done_en = 1'b0;
    base = run_total;
    pulse_start(7'd0);
    wait_issue("t4_issue", 9'h081);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clock);
      n++;
      if (error) break;
    end
    check_eq("t4_wd_cycles", 32'(n), 32'(TIMEOUT + 1));
    pulse_start(7'd0);
    repeat (4) @(negedge Clock);
    check_eq("t4_sticky", 32'(error), 32'd1);
    check_eq("t4_run", 32'(Run), 32'd0);
    check_eq("t4_busy", 32'(busy), 32'd0);
    check_eq("t4_runs", 32'(run_total - base), 32'd1);
    done_en = 1'b1;

    // 5: halt_req during a long instruction
    do_reset();
    clear_rom();
    rom[0] = 9'h040; rom[1] = 9'h003; rom[2] = 9'h048; rom[3] = 9'h004;
    rom[4] = 9'h081; rom[5] = 9'h1C0;
    pulse_start(7'd0);
    wait_issue("t5_issue", 9'h081);
    @(negedge Clock);
    halt_req = 1'b1;
    wait_halted("t5_halt");
    halt_req = 1'b0;
    check_eq("t5_r0", 32'(r[0]), 32'd7);
    check_eq("t5_cnt", 32'(instr_cnt), 32'd3);
    check_eq("t5_pc", 32'(pc), 32'd5);

    // 6: reset while waiting for Done, then clean rerun
    do_reset();
    load_prog1();
    pulse_start(7'd0);
    wait_issue("t6_issue", 9'h081);
    @(negedge Clock);
    #1 Resetn = 1'b0;
    #1;
    check_eq("t6_pc", 32'(pc), 32'd0);
    check_eq("t6_cnt", 32'(instr_cnt), 32'd0);
    check_eq("t6_outs", {22'd0, DIN, Run}, 32'd0);
    check_eq("t6_flags", {29'd0, busy, halted, error}, 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    pulse_start(7'd0);
    wait_halted("t6_halt");
    check_eq("t6_r0", 32'(r[0]), 32'd10);
    check_eq("t6_cnt2", 32'(instr_cnt), 32'd3);

    check_eq("run_double", 32'(run_double), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
